image_block_avg_stream: RTL and testbench



---
 rtl/img_resize_pkg.sv | 34 +++
 rtl/image_block_avg_stream_seq_udiv.sv | 62 ++++++
 rtl/image_block_avg_stream.sv | 211 +++++++++++++++++++++
 tb/tb_image_block_avg_stream.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_resize_pkg.sv
// Shared FSM encoding and geometry helpers for the block-averaging downscaler.
package img_resize_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_READ      = 3'd1;
  localparam state_t S_WAIT_DATA = 3'd2;
  localparam state_t S_DIVIDE    = 3'd3;
  localparam state_t S_SEND      = 3'd4;
  localparam state_t S_WAIT_TX   = 3'd5;

  function automatic int calc_bw(input int src_w, input int dst_w);
    return src_w / dst_w;
  endfunction

  function automatic int calc_bh(input int src_h, input int dst_h);
    return src_h / dst_h;
  endfunction

  function automatic int calc_n(input int bw, input int bh);
    return bw * bh;
  endfunction

  function automatic int calc_acc_w(input int pix_w, input int n);
    return pix_w + $clog2(n);
  endfunction

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_block_avg_stream_seq_udiv.sv
// Restoring unsigned divider: quotient/valid arrive WIDTH+1 cycles after start.
module seq_udiv #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] den;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] sub;
  logic             ge;

  // The true difference is below the divisor, so WIDTH-bit wraparound is exact.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, den});
    sub    = rem_sh[WIDTH-1:0] - den;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      den   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        rem <= '0;
        quo <= dividend;
        den <= divisor;
        cnt <= CNT_W'(WIDTH);
        run <= 1'b1;
      end else if (run) begin
        rem <= ge ? sub : rem_sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ge};
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          run   <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/image_block_avg_stream.sv
// Streaming block-average downscaler: SDRAM raster read -> row accumulators -> divider -> UART.
// Define AVG_ROUND_EN for round-half-up averages instead of floor.
module image_block_avg_stream
  import img_resize_pkg::*;
#(
  parameter int SRC_W     = 640,
  parameter int SRC_H     = 480,
  parameter int DST_W     = 32,
  parameter int DST_H     = 32,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 23,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  tx_data,
  output logic              tx_trmt,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam int BW    = calc_bw(SRC_W, DST_W);
  localparam int BH    = calc_bh(SRC_H, DST_H);
  localparam int N     = calc_n(BW, BH);
  localparam int ACC_W = calc_acc_w(PIX_W, N);
`ifdef AVG_ROUND_EN
  localparam int DIV_W = ACC_W + 1;
`else
  localparam int DIV_W = ACC_W;
`endif
  localparam int XW  = idx_w(SRC_W);
  localparam int PW  = idx_w(BW);
  localparam int CW  = idx_w(DST_W);
  localparam int RW  = idx_w(BH);
  localparam int BRW = idx_w(DST_H);

  localparam logic [XW-1:0]    X_LAST  = XW'(SRC_W - 1);
  localparam logic [PW-1:0]    P_LAST  = PW'(BW - 1);
  localparam logic [CW-1:0]    C_LAST  = CW'(DST_W - 1);
  localparam logic [RW-1:0]    R_LAST  = RW'(BH - 1);
  localparam logic [BRW-1:0]   BR_LAST = BRW'(DST_H - 1);
  localparam logic [DIV_W-1:0] DIVISOR = DIV_W'(N);
  localparam logic [DIV_W-1:0] Q_MAX   = DIV_W'((1 << PIX_W) - 1);

  state_t            state;
  logic [XW-1:0]     x;
  logic [PW-1:0]     px;
  logic [CW-1:0]     bx;
  logic [CW-1:0]     col;
  logic [CW-1:0]     div_idx;
  logic [RW-1:0]     ry;
  logic [BRW-1:0]    brow;
  logic [ADDR_W-1:0] addr;
  logic              div_run;
  logic              tx_low_seen;
  logic [ACC_W-1:0]  acc  [DST_W];
  logic [PIX_W-1:0]  quot [DST_W];

  logic              div_start;
  logic              div_valid;
  logic [DIV_W-1:0]  div_dividend;
  logic [DIV_W-1:0]  div_quot;
  logic [PIX_W-1:0]  quot_byte;

  always_comb begin
    div_start = (state == S_DIVIDE) && !div_run;
`ifdef AVG_ROUND_EN
    div_dividend = {1'b0, acc[div_idx]} + DIV_W'(N / 2);
`else
    div_dividend = acc[div_idx];
`endif
    quot_byte = (div_quot > Q_MAX) ? '1 : div_quot[PIX_W-1:0];
  end

  seq_udiv #(.WIDTH(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (DIVISOR),
    .quotient (div_quot),
    .valid    (div_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      tx_data     <= '0;
      tx_trmt     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      x           <= '0;
      px          <= '0;
      bx          <= '0;
      col         <= '0;
      div_idx     <= '0;
      ry          <= '0;
      brow        <= '0;
      addr        <= '0;
      div_run     <= 1'b0;
      tx_low_seen <= 1'b0;
      for (int i = 0; i < DST_W; i++) begin
        acc[i]  <= '0;
        quot[i] <= '0;
      end
    end else begin
      rd_req  <= 1'b0;
      tx_trmt <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_READ;
            busy    <= 1'b1;
            done    <= 1'b0;
            x       <= '0;
            px      <= '0;
            bx      <= '0;
            ry      <= '0;
            brow    <= '0;
            col     <= '0;
            div_idx <= '0;
            addr    <= ADDR_W'(BASE_ADDR);
          end
        end
        S_READ: begin
          rd_req  <= 1'b1;
          rd_addr <= addr;
          state   <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (rd_valid) begin
            acc[bx] <= acc[bx] + ACC_W'(rd_data);
            addr    <= addr + 1'b1;
            if (x == X_LAST) begin
              x  <= '0;
              px <= '0;
              bx <= '0;
              if (ry == R_LAST) begin
                ry      <= '0;
                div_idx <= '0;
                state   <= S_DIVIDE;
              end else begin
                ry    <= ry + 1'b1;
                state <= S_READ;
              end
            end else begin
              x     <= x + 1'b1;
              state <= S_READ;
              if (px == P_LAST) begin
                px <= '0;
                bx <= bx + 1'b1;
              end else begin
                px <= px + 1'b1;
              end
            end
          end
        end
        // Each accumulator is cleared as its quotient is captured, ready for the next block row.
        S_DIVIDE: begin
          if (div_start) div_run <= 1'b1;
          if (div_valid) begin
            quot[div_idx] <= quot_byte;
            acc[div_idx]  <= '0;
            div_run       <= 1'b0;
            if (div_idx == C_LAST) begin
              col   <= '0;
              state <= S_SEND;
            end else begin
              div_idx <= div_idx + 1'b1;
            end
          end
        end
        S_SEND: begin
          if (tx_done) begin
            tx_data     <= quot[col];
            tx_trmt     <= 1'b1;
            tx_low_seen <= 1'b0;
            state       <= S_WAIT_TX;
          end
        end
        S_WAIT_TX: begin
          if (!tx_done) begin
            tx_low_seen <= 1'b1;
          end else if (tx_low_seen) begin
            if (col != C_LAST) begin
              col   <= col + 1'b1;
              state <= S_SEND;
            end else if (brow == BR_LAST) begin
              state <= S_IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              brow  <= brow + 1'b1;
              state <= S_READ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_block_avg_stream.sv
// Scoreboard bench: a 4x4->2x2 instance (pixel=offset, flats, hold, abort) and a 300x1->1x1 sum-450 instance.
module tb_image_block_avg_stream;

  localparam int A_BASE = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, rd_valid_a = 1'b0, tx_done_a = 1'b1;
  logic [7:0]  rd_data_a = '0;
  logic        rd_req_a, tx_trmt_a, busy_a, done_a;
  logic [22:0] rd_addr_a;
  logic [7:0]  tx_data_a;

  logic        start_b = 1'b0, rd_valid_b = 1'b0, tx_done_b = 1'b1;
  logic [7:0]  rd_data_b = '0;
  logic        rd_req_b, tx_trmt_b, busy_b, done_b;
  logic [22:0] rd_addr_b;
  logic [7:0]  tx_data_b;

  image_block_avg_stream #(
    .SRC_W(4), .SRC_H(4), .DST_W(2), .DST_H(2), .PIX_W(8), .ADDR_W(23), .BASE_ADDR(A_BASE)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rd_req(rd_req_a), .rd_addr(rd_addr_a),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a), .tx_data(tx_data_a), .tx_trmt(tx_trmt_a),
    .tx_done(tx_done_a), .busy(busy_a), .done(done_a)
  );

  image_block_avg_stream #(
    .SRC_W(300), .SRC_H(1), .DST_W(1), .DST_H(1), .PIX_W(8), .ADDR_W(23), .BASE_ADDR(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rd_req(rd_req_b), .rd_addr(rd_addr_b),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .tx_data(tx_data_b), .tx_trmt(tx_trmt_b),
    .tx_done(tx_done_b), .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b_q[$];
  int          pat = 0;
  int          hold_max = 4;
  int          rd_count_a = 0;
  int          rd_count_b = 0;
  logic [22:0] exp_addr_a = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [7:0] pix_a(input logic [22:0] a);
    case (pat)
      0:       return 8'(a - 23'(A_BASE));
      1:       return 8'hFF;
      default: return 8'h80;
    endcase
  endfunction

  // SDRAM model for instance A: one request at a time, 1..3 cycle latency.
  initial begin
    logic [22:0] a;
    forever begin
      @(negedge clk);
      if (rd_req_a === 1'b1) begin
        a = rd_addr_a;
        rd_count_a++;
        check("rd_addr_a", a, exp_addr_a);
        exp_addr_a = exp_addr_a + 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rd_data_a  = pix_a(a);
        rd_valid_a = 1'b1;
        @(negedge clk);
        rd_valid_a = 1'b0;
      end
    end
  end

  // UART model for instance A: tx_done low for a variable time after each strobe.
  initial begin
    int extra;
    int h;
    forever begin
      @(negedge clk);
      if (tx_trmt_a === 1'b1) begin
        extra     = 0;
        tx_done_a = 1'b0;
        h = (hold_max >= 50) ? hold_max : $urandom_range(1, hold_max);
        for (int i = 0; i < h; i++) begin
          @(negedge clk);
          if (tx_trmt_a === 1'b1) extra++;
        end
        tx_done_a = 1'b1;
        check("no_extra_strobe_a", extra, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (tx_trmt_a === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_byte_a: unexpected byte %0d with empty queue", tx_data_a);
      end else begin
        check("tx_byte_a", tx_data_a, exp_q.pop_front());
      end
    end
  end

  // Instance B: fixed one-cycle latency, first 150 pixels are 3, the rest 0.
  initial begin
    logic [22:0] a;
    forever begin
      @(negedge clk);
      if (rd_req_b === 1'b1) begin
        a = rd_addr_b;
        rd_count_b++;
        @(negedge clk);
        rd_data_b  = (a < 23'd150) ? 8'd3 : 8'd0;
        rd_valid_b = 1'b1;
        @(negedge clk);
        rd_valid_b = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_trmt_b === 1'b1) begin
        tx_done_b = 1'b0;
        repeat (3) @(negedge clk);
        tx_done_b = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (tx_trmt_b === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_byte_b: unexpected byte %0d with empty queue", tx_data_b);
      end else begin
        check("tx_byte_b", tx_data_b, exp_b_q.pop_front());
      end
    end
  end

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("busy_after_start_a", busy_a, 1);
    check("done_cleared_a", done_a, 0);
  endtask

  task automatic wait_done_a(input int budget);
    int k = 0;
    while (done_a !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_a", done_a, 1);
  endtask

  task automatic run_frame_a(input int p, input int hold, input logic [7:0] e[4], input bit restart);
    pat        = p;
    hold_max   = hold;
    exp_addr_a = 23'(A_BASE);
    rd_count_a = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(e[i]);
    pulse_start_a();
    if (restart) begin
      repeat (20) @(negedge clk);
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    wait_done_a(20000);
    check("busy_low_at_done_a", busy_a, 0);
    check("rd_count_a", rd_count_a, 16);
    check("queue_drained_a", exp_q.size(), 0);
  endtask

  logic [7:0] e_addr[4];
  logic [7:0] e_ff[4]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] e_80[4]  = '{8'h80, 8'h80, 8'h80, 8'h80};

  initial begin
    int saved;
    int k;
`ifdef AVG_ROUND_EN
    e_addr = '{8'd3, 8'd5, 8'd11, 8'd13};
`else
    e_addr = '{8'd2, 8'd4, 8'd10, 8'd12};
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rd_req", rd_req_a, 0);
    check("reset_rd_addr", rd_addr_a, 0);
    check("reset_tx_trmt", tx_trmt_a, 0);
    check("reset_tx_data", tx_data_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame_a(0, 4, e_addr, 1'b0);
    repeat (5) @(negedge clk);
    check("done_holds_a", done_a, 1);

    // Long UART hold plus a second start while busy.
    run_frame_a(1, 50, e_ff, 1'b1);

    // Abort mid-frame, then confirm a clean restart.
    pat        = 1;
    exp_addr_a = 23'(A_BASE);
    rd_count_a = 0;
    pulse_start_a();
    k = 0;
    while (rd_count_a < 5 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reached_pixel_5", rd_count_a, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_rd_req", rd_req_a, 0);
    check("abort_tx_trmt", tx_trmt_a, 0);
    saved = rd_count_a;
    repeat (20) @(negedge clk);
    check("no_rd_after_abort", rd_count_a, saved);

    run_frame_a(0, 3, e_addr, 1'b0);
    run_frame_a(2, 2, e_80, 1'b0);

`ifdef AVG_ROUND_EN
    exp_b_q.push_back(8'd2);
`else
    exp_b_q.push_back(8'd1);
`endif
    rd_count_b = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("busy_after_start_b", busy_b, 1);
    k = 0;
    while (done_b !== 1'b1 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("done_b", done_b, 1);
    check("rd_count_b", rd_count_b, 300);
    check("queue_drained_b", exp_b_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
